// File: rtl/mips_pkg.sv
// Shared types and constants for the fetch stage: FSM encoding, instruction width,
// the opcode values the decoder keys on, and the branch-immediate sign extender.
package mips_pkg;

  localparam int INSN_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    ERR  = 3'd4
  } fetch_state_t;

  function automatic logic [31:0] sext16_32(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC select: jump > taken branch > sequential, all mod 2^32.
// The jump path exists only when FETCH_JUMP_EN is defined.
module pc_next_calc
  import mips_pkg::*;
(
  input  logic [31:0] ins_pc,
  input  logic        branch_taken,
  input  logic [15:0] branch_imm,
`ifdef FETCH_JUMP_EN
  input  logic        jump,
  input  logic [25:0] jump_idx,
`endif
  output logic [31:0] next_pc
);

  logic [31:0] seq;
  logic [31:0] imm_ext;
  logic [31:0] br;

  assign seq     = ins_pc + 32'd4;
  assign imm_ext = sext16_32(branch_imm);
  assign br      = seq + (imm_ext << 2);

  always_comb begin
    next_pc = seq;
    if (branch_taken) next_pc = br;
`ifdef FETCH_JUMP_EN
    // j-type keeps the top nibble of the delay-slot address
    if (jump) next_pc = {seq[31:28], jump_idx, 2'b00};
`endif
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC register, imem req/ready handshake, single-entry instruction holding
// register toward decode, and a memory timeout. Optional jump path: FETCH_JUMP_EN.
module instr_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [31:0]       imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [INSN_W-1:0] ins,
  output logic [31:0]       ins_pc,
  input  logic              branch_taken,
  input  logic [15:0]       branch_imm,
`ifdef FETCH_JUMP_EN
  input  logic              jump,
  input  logic [25:0]       jump_idx,
`endif
  output logic              fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 2);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  fetch_state_t     state, state_nxt;
  logic [31:0]      pc;
  logic [31:0]      next_pc;
  logic [CNT_W-1:0] cnt;
  logic             capture;
  logic             accept;
  logic             timed_out;

  pc_next_calc u_pc_next (
    .ins_pc       (ins_pc),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
`ifdef FETCH_JUMP_EN
    .jump         (jump),
    .jump_idx     (jump_idx),
`endif
    .next_pc      (next_pc)
  );

  assign imem_req  = (state == REQ) || (state == WAIT);
  assign imem_addr = pc;
  assign ins_valid = (state == HOLD);
  assign fetch_err = (state == ERR);
  assign capture   = imem_req && imem_ready;
  assign accept    = ins_valid && ins_ready;
  // cnt holds completed WAIT cycles; this cycle is the TIMEOUT_CYC-th
  assign timed_out = (TIMEOUT_CYC != 0) && (state == WAIT) && (cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = REQ;
      REQ, WAIT: begin
        if (imem_ready)     state_nxt = HOLD;
        else if (timed_out) state_nxt = ERR;
        else                state_nxt = WAIT;
      end
      HOLD: if (ins_ready) state_nxt = REQ;
      ERR:  state_nxt = ERR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= RESET_PC;
      ins    <= '0;
      ins_pc <= '0;
      cnt    <= '0;
    end else begin
      if (capture) begin
        ins    <= imem_rdata;
        ins_pc <= pc;
      end
      if (accept) pc <= next_pc;
      if (state == WAIT && !imem_ready) cnt <= cnt + 1'b1;
      else                              cnt <= '0;
    end
  end

  a_addr_aligned: assert property (@(posedge clk) imem_addr[1:0] == 2'b00)
    else $error("instr_fetch: misaligned fetch address (check RESET_PC)");

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: reset, zero-wait stream, branches, wrap, stall, timeout,
// and (with FETCH_JUMP_EN) jump priority. Memory returns ~addr as the instruction word.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic [31:0] ins;
  logic [31:0] ins_pc;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_imm = '0;
`ifdef FETCH_JUMP_EN
  logic        jump = 1'b0;
  logic [25:0] jump_idx = '0;
`endif
  logic        fetch_err;

  int errors = 0;
  int checks = 0;
  int mem_lat = 0;
  bit mem_dead = 1'b0;
  int wcnt = 0;

  instr_fetch #(.RESET_PC(32'h0), .TIMEOUT_CYC(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .ins_valid    (ins_valid),
    .ins_ready    (ins_ready),
    .ins          (ins),
    .ins_pc       (ins_pc),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
`ifdef FETCH_JUMP_EN
    .jump         (jump),
    .jump_idx     (jump_idx),
`endif
    .fetch_err    (fetch_err)
  );

  always #5 clk = ~clk;

  // Memory: answers on the (mem_lat+1)-th consecutive request cycle
  always @(negedge clk) begin
    if (imem_req) begin
      if (!mem_dead && wcnt >= mem_lat) begin
        imem_ready = 1'b1;
        imem_rdata = ~imem_addr;
      end else begin
        imem_ready = 1'b0;
      end
      wcnt = wcnt + 1;
    end else begin
      imem_ready = 1'b0;
      wcnt = 0;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Advance until the target instruction is held; redirect inputs are wiggled
  // on every non-accept cycle, where they must be ignored.
  task automatic run_to(input logic [31:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ins_valid && ins_pc == target) begin
        ok = 1'b1;
        return;
      end
      branch_taken = ~ins_valid;
      branch_imm   = 16'h0100;
`ifdef FETCH_JUMP_EN
      jump     = ~ins_valid;
      jump_idx = 26'h3FF_FFFF;
`endif
    end
  endtask

  task automatic test_reset();
    ins_ready = 1'b0;
    mem_lat = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b expected 0", imem_req); end
    checks++; if (ins_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b expected 0", ins_valid); end
    checks++; if (fetch_err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b expected 0", fetch_err); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h expected 00000000", imem_addr); end
    checks++; if (ins !== 32'h0) begin errors++; $display("FAIL rst_ins: got %h expected 00000000", ins); end
    checks++; if (ins_pc !== 32'h0) begin errors++; $display("FAIL rst_ins_pc: got %h expected 00000000", ins_pc); end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr);
    end
  endtask

  task automatic test_stream();
    mem_lat = 0;
    ins_ready = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k) || ins_valid !== 1'b0) begin
        errors++; $display("FAIL stream_req%0d: got req=%b addr=%h valid=%b expected req=1 addr=%h valid=0",
                           k, imem_req, imem_addr, ins_valid, 32'(4 * k));
      end
      @(negedge clk);
      checks++;
      if (ins_valid !== 1'b1 || ins_pc !== 32'(4 * k) || ins !== ~32'(4 * k) || imem_req !== 1'b0) begin
        errors++; $display("FAIL stream_ins%0d: got valid=%b pc=%h ins=%h req=%b expected valid=1 pc=%h ins=%h req=0",
                           k, ins_valid, ins_pc, ins, imem_req, 32'(4 * k), ~32'(4 * k));
      end
    end
  endtask

  task automatic test_branch();
    bit ok;
    mem_lat = 0;
    ins_ready = 1'b1;
    do_reset();
    run_to(32'h10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL br_reach10: got no ins at 00000010 expected one"); end
    branch_taken = 1'b1; branch_imm = 16'hFFFC;
    @(negedge clk);
    branch_taken = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin
      errors++; $display("FAIL br_back: got req=%b addr=%h expected req=1 addr=00000004", imem_req, imem_addr);
    end
    run_to(32'h4, ok);
    checks++;
    if (!ok || ins !== ~32'h4) begin
      errors++; $display("FAIL br_back_ins: got ok=%b ins=%h expected ok=1 ins=%h", ok, ins, ~32'h4);
    end
    run_to(32'h10, ok);
    branch_taken = 1'b1; branch_imm = 16'h0003;
    @(negedge clk);
    branch_taken = 1'b0;
    checks++;
    if (!ok || imem_req !== 1'b1 || imem_addr !== 32'h20) begin
      errors++; $display("FAIL br_fwd: got ok=%b req=%b addr=%h expected ok=1 req=1 addr=00000020", ok, imem_req, imem_addr);
    end
    @(negedge clk);
    checks++;
    if (ins_valid !== 1'b1 || ins_pc !== 32'h20) begin
      errors++; $display("FAIL br_fwd_ins: got valid=%b pc=%h expected valid=1 pc=00000020", ins_valid, ins_pc);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    mem_lat = 0;
    ins_ready = 1'b1;
    do_reset();
    run_to(32'h0, ok);
    branch_taken = 1'b1; branch_imm = 16'hFFFE;
    @(negedge clk);
    branch_taken = 1'b0;
    checks++;
    if (!ok || imem_addr !== 32'hFFFF_FFFC) begin
      errors++; $display("FAIL wrap_neg: got ok=%b addr=%h expected ok=1 addr=fffffffc", ok, imem_addr);
    end
    run_to(32'hFFFF_FFFC, ok);
    branch_taken = 1'b0;
`ifdef FETCH_JUMP_EN
    jump = 1'b0;
`endif
    @(negedge clk);
    checks++;
    if (!ok || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL wrap_seq: got ok=%b req=%b addr=%h expected ok=1 req=1 addr=00000000", ok, imem_req, imem_addr);
    end
  endtask

  task automatic test_stall();
    mem_lat = 3;
    ins_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0 || ins_valid !== 1'b0) begin
        errors++; $display("FAIL stall_wait%0d: got req=%b addr=%h valid=%b expected req=1 addr=00000000 valid=0",
                           i, imem_req, imem_addr, ins_valid);
      end
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (ins_valid !== 1'b1 || imem_req !== 1'b0 || ins_pc !== 32'h0 || ins !== 32'hFFFF_FFFF) begin
        errors++; $display("FAIL stall_hold%0d: got valid=%b req=%b pc=%h ins=%h expected valid=1 req=0 pc=00000000 ins=ffffffff",
                           i, ins_valid, imem_req, ins_pc, ins);
      end
    end
    ins_ready = 1'b1;
    @(negedge clk);
    ins_ready = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h4 || ins_valid !== 1'b0) begin
      errors++; $display("FAIL stall_release: got req=%b addr=%h valid=%b expected req=1 addr=00000004 valid=0",
                         imem_req, imem_addr, ins_valid);
    end
  endtask

  task automatic test_timeout();
    mem_lat = 0;
    mem_dead = 1'b1;
    ins_ready = 1'b1;
    do_reset();
    // one REQ cycle plus four WAIT cycles with the request up
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (imem_req !== 1'b1 || fetch_err !== 1'b0) begin
        errors++; $display("FAIL to_wait%0d: got req=%b err=%b expected req=1 err=0", i, imem_req, fetch_err);
      end
    end
    @(negedge clk);
    checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0 || ins_valid !== 1'b0) begin
      errors++; $display("FAIL to_err: got err=%b req=%b valid=%b expected err=1 req=0 valid=0", fetch_err, imem_req, ins_valid);
    end
    mem_dead = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (fetch_err !== 1'b1 || imem_req !== 1'b0) begin
      errors++; $display("FAIL to_sticky: got err=%b req=%b expected err=1 req=0", fetch_err, imem_req);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (fetch_err !== 1'b0) begin
      errors++; $display("FAIL to_clear: got err=%b expected 0", fetch_err);
    end
    do_reset();
    @(negedge clk);
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL to_restart: got req=%b addr=%h expected req=1 addr=00000000", imem_req, imem_addr);
    end
  endtask

`ifdef FETCH_JUMP_EN
  task automatic test_jump();
    bit ok;
    mem_lat = 0;
    ins_ready = 1'b1;
    do_reset();
    run_to(32'h0, ok);
    branch_taken = 1'b1; branch_imm = 16'hFFFD; jump = 1'b0;
    @(negedge clk);
    branch_taken = 1'b0;
    checks++;
    if (!ok || imem_addr !== 32'hFFFF_FFF8) begin
      errors++; $display("FAIL jmp_setup: got ok=%b addr=%h expected ok=1 addr=fffffff8", ok, imem_addr);
    end
    run_to(32'hFFFF_FFF8, ok);
    jump = 1'b1; jump_idx = 26'h0; branch_taken = 1'b1; branch_imm = 16'h0003;
    @(negedge clk);
    jump = 1'b0; branch_taken = 1'b0;
    checks++;
    if (!ok || imem_addr !== 32'hF000_0000) begin
      errors++; $display("FAIL jmp_hi: got ok=%b addr=%h expected ok=1 addr=f0000000", ok, imem_addr);
    end
    run_to(32'hF000_0000, ok);
    jump = 1'b1; jump_idx = 26'h10; branch_taken = 1'b1; branch_imm = 16'h0003;
    @(negedge clk);
    jump = 1'b0; branch_taken = 1'b0;
    checks++;
    if (!ok || imem_req !== 1'b1 || imem_addr !== 32'hF000_0040) begin
      errors++; $display("FAIL jmp_prio: got ok=%b req=%b addr=%h expected ok=1 req=1 addr=f0000040", ok, imem_req, imem_addr);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_branch();
    test_wrap();
    test_stall();
    test_timeout();
`ifdef FETCH_JUMP_EN
    test_jump();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
